frame_sequencer: RTL
====================

# frame_sequencer

Front-end controller for the detection pipeline.
- Accepts a raster-order RGB pixel stream over a valid/ready handshake and drives the pipeline's `en`, `x`, `y` and `data` inputs.
- At frame end, issues flush cycles so the pipeline's line buffers and windows empty out.
- Then walks `obj_id` through every connected-components label and emits one statistics record per object on a second valid/ready stream.
- Sits between the pixel source and the pipeline top level; only one frame is in flight at a time.

## Interface
Parameters:
- FRAME_WIDTH, default `FRAME_WIDTH: pixels per line.
- FRAME_HEIGHT, default `FRAME_HEIGHT: lines per frame.
- FLUSH_CYCLES, default 2*`FRAME_WIDTH+8: zero-data `en` cycles issued after the last pixel.
- STAT_WAIT, default 2: cycles `obj_id` is held before object statistics are sampled (must be ≥1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  sequencer can accept a pixel.
- s_data  in  `PIXEL_SIZE  input RGB pixel.
- pix_en  out  1  pipeline enable.
- pix_x  out  `LOC_SIZE  pipeline x coordinate.
- pix_y  out  `LOC_SIZE  pipeline y coordinate.
- pix_data  out  `PIXEL_SIZE  pipeline pixel data.
- num_labels  in  `LBL_WIDTH  label count from the pipeline.
- obj_area  in  `LOC_SIZE  statistic for the selected object.
- obj_x  in  `LOC_SIZE  statistic for the selected object.
- obj_y  in  `LOC_SIZE  statistic for the selected object.
- obj_id  out  `LBL_WIDTH  object selector to the pipeline.
- stat_valid  out  1  statistics record valid.
- stat_ready  in  1  downstream accepts the record.
- stat_id  out  `LBL_WIDTH  record field.
- stat_area  out  `LOC_SIZE  record field.
- stat_x  out  `LOC_SIZE  record field.
- stat_y  out  `LOC_SIZE  record field.
- frame_done  out  1  one-cycle pulse when a frame is fully processed.
- busy  out  1  high in every state except STREAM.

## Operation
- States: STREAM, FLUSH, SET, OUT, DONE. Reset enters STREAM.
- Reset values: all outputs 0, except s_ready=1.
- STREAM:
  - s_ready=1; a pixel is accepted when s_valid&s_ready.
  - Counters cx, cy advance per accepted pixel only. cx wraps at FRAME_WIDTH-1 and increments cy.
  - Accepting pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1) moves to FLUSH; cx and cy go to 0 and FRAME_HEIGHT.
- FLUSH:
  - s_ready=0; pix_en=1 every cycle with pix_data=0.
  - Coordinates keep raster-advancing, so y ≥ FRAME_HEIGHT.
  - Runs exactly FLUSH_CYCLES cycles, then latches L=num_labels and id=1.
  - Goes to SET if L≠0, otherwise to DONE.
- SET:
  - obj_id=id, registered on entry. Held STAT_WAIT cycles.
  - On the last SET cycle, obj_area/obj_x/obj_y and id are captured into the stat_* registers; next state is OUT.
- OUT:
  - stat_valid=1; stat_* and obj_id are held stable until stat_ready.
  - On stat_valid&stat_ready: if id==L go to DONE, else id++ and go to SET.
- DONE: frame_done=1 for one cycle; cx=cy=0; obj_id=0; next state STREAM.
- Label 0 is background and is never reported.
- num_labels is sampled once per frame; changes after the latch are ignored.
- Reset in any state aborts immediately: STREAM, counters 0, stat_valid=0, no frame_done.

## Timing
- Pixel path latency is 1 cycle. pix_en, pix_x, pix_y, pix_data are registered; a pixel accepted in cycle n appears in cycle n+1 with its own coordinates.
- pix_en=0 in any cycle following a non-accepting cycle in STREAM.
- s_ready is a pure state decode and never depends on s_valid.
- Last pixel accepted in cycle n:
  - s_ready=0 from n+1.
  - Flush pix_en cycles occupy n+2 … n+1+FLUSH_CYCLES.
- First SET cycle is n+2+FLUSH_CYCLES.
- SET→OUT: stat_valid rises STAT_WAIT cycles after obj_id changes.
- Minimum per object, with stat_ready tied high: STAT_WAIT+1 cycles.
- frame_done asserts the cycle after the final handshake, or the cycle after FLUSH when L=0. s_ready=1 on the following cycle.
- All state and counters are LOC_SIZE/LBL_WIDTH wide; no arithmetic overflow is possible for legal parameters.

## Test plan
Common parameters: FRAME_WIDTH=4, FRAME_HEIGHT=3, FLUSH_CYCLES=3, STAT_WAIT=2.

- Reset: assert reset for 2 cycles with s_valid=1 → pix_en=0, stat_valid=0, frame_done=0, obj_id=0, s_ready=1, busy=0.
- Continuous stream: 12 back-to-back pixels with data=index →
  - pix_en high 12 cycles starting 1 cycle after the first acceptance.
  - (x,y) sequence (0,0)…(3,2); pix_data matches.
  - s_ready low the cycle after the 12th acceptance.
  - 3 flush cycles with data 0 at (0,3),(1,3),(2,3).
- Gapped stream: s_valid pattern 1,0,0,1 → pix_en 1,0,0,1 (delayed one cycle); x advances 0→1 only on acceptance.
- Object scan: num_labels=3, obj_area=10*obj_id, stat_ready=1 →
  - obj_id 1,2,3, each SET for 2 cycles.
  - Three records (1,10),(2,20),(3,30).
  - One frame_done, then s_ready=1.
- Backpressure: stat_ready=0 for 5 cycles during OUT → stat_valid and all stat_* fields and obj_id held constant; advance occurs only on the handshake cycle.
- Edge cases:
  - num_labels=0 → frame_done the cycle after the last flush cycle, no stat_valid.
  - reset asserted mid-OUT → next cycle stat_valid=0, s_ready=1, no frame_done.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: feeds one raster frame into the detection pipeline,
// flushes it, then reads back one statistics record per labelled object.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   s_valid/s_ready   input pixel handshake, s_data = RGB pixel
//   pix_en/x/y/data   registered pipeline drive (1-cycle latency)
//   num_labels        label count from the pipeline, latched after flush
//   obj_area/x/y      statistics for the object selected by obj_id
//   stat_valid/ready  statistics record handshake
//   stat_id/area/x/y  record fields, stable while stat_valid is high
//   frame_done        one-cycle pulse when a frame is fully processed
//   busy              high whenever not accepting pixels

`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 16
`endif
`ifndef LBL_WIDTH
`define LBL_WIDTH 8
`endif
`ifndef FRAME_WIDTH
`define FRAME_WIDTH 640
`endif
`ifndef FRAME_HEIGHT
`define FRAME_HEIGHT 480
`endif

module frame_sequencer #(
   parameter int FRAME_WIDTH  = `FRAME_WIDTH,
   parameter int FRAME_HEIGHT = `FRAME_HEIGHT,
   parameter int FLUSH_CYCLES = 2*`FRAME_WIDTH+8,
   parameter int STAT_WAIT    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [`PIXEL_SIZE-1:0] s_data,
   output logic                   pix_en,
   output logic [`LOC_SIZE-1:0]   pix_x,
   output logic [`LOC_SIZE-1:0]   pix_y,
   output logic [`PIXEL_SIZE-1:0] pix_data,
   input  logic [`LBL_WIDTH-1:0]  num_labels,
   input  logic [`LOC_SIZE-1:0]   obj_area,
   input  logic [`LOC_SIZE-1:0]   obj_x,
   input  logic [`LOC_SIZE-1:0]   obj_y,
   output logic [`LBL_WIDTH-1:0]  obj_id,
   output logic                   stat_valid,
   input  logic                   stat_ready,
   output logic [`LBL_WIDTH-1:0]  stat_id,
   output logic [`LOC_SIZE-1:0]   stat_area,
   output logic [`LOC_SIZE-1:0]   stat_x,
   output logic [`LOC_SIZE-1:0]   stat_y,
   output logic                   frame_done,
   output logic                   busy
);

   localparam int LW = `LOC_SIZE;
   localparam int BW = `LBL_WIDTH;
   localparam int PW = `PIXEL_SIZE;

   localparam logic [LW-1:0] X_LAST  = LW'(FRAME_WIDTH - 1);
   localparam logic [LW-1:0] Y_LAST  = LW'(FRAME_HEIGHT - 1);
   localparam logic [LW-1:0] FL_N    = LW'(FLUSH_CYCLES);
   localparam logic [LW-1:0] WT_LAST = LW'(STAT_WAIT - 1);

   typedef enum logic [2:0] {
      STREAM,
      FLUSH,
      SET,
      OUT,
      DONE
   } state_t;

   state_t state, state_n;

   logic [LW-1:0] cx, cx_n;
   logic [LW-1:0] cy, cy_n;
   logic [LW-1:0] cnt, cnt_n;
   logic [BW-1:0] lbl, lbl_n;
   logic [BW-1:0] id, id_n;
   logic [BW-1:0] oid_n;
   logic [BW-1:0] sid_n;
   logic [LW-1:0] sa_n;
   logic [LW-1:0] sx_n;
   logic [LW-1:0] sy_n;
   logic          pen_n;
   logic [LW-1:0] px_n;
   logic [LW-1:0] py_n;
   logic [PW-1:0] pd_n;

   // Raster successor of the current coordinate pair.
   logic          x_wrap;
   logic [LW-1:0] nx;
   logic [LW-1:0] ny;

   assign x_wrap = (cx == X_LAST);
   assign nx     = x_wrap ? '0 : cx + LW'(1);
   assign ny     = x_wrap ? cy + LW'(1) : cy;

   assign s_ready    = (state == STREAM);
   assign busy       = (state != STREAM);
   assign stat_valid = (state == OUT);
   assign frame_done = (state == DONE);

   always_comb begin
      state_n = state;
      cx_n    = cx;
      cy_n    = cy;
      cnt_n   = cnt;
      lbl_n   = lbl;
      id_n    = id;
      oid_n   = obj_id;
      sid_n   = stat_id;
      sa_n    = stat_area;
      sx_n    = stat_x;
      sy_n    = stat_y;
      pen_n   = 1'b0;
      px_n    = pix_x;
      py_n    = pix_y;
      pd_n    = pix_data;

      unique case (state)
         STREAM: begin
            if (s_valid) begin
               pen_n = 1'b1;
               px_n  = cx;
               py_n  = cy;
               pd_n  = s_data;
               cx_n  = nx;
               cy_n  = ny;
               // Wrap of the last pixel leaves cx=0, cy=FRAME_HEIGHT,
               // so flush coordinates continue below the frame.
               if (x_wrap && cy == Y_LAST) begin
                  cnt_n   = '0;
                  state_n = FLUSH;
               end
            end
         end

         FLUSH: begin
            if (cnt != FL_N) begin
               pen_n = 1'b1;
               px_n  = cx;
               py_n  = cy;
               pd_n  = '0;
               cx_n  = nx;
               cy_n  = ny;
               cnt_n = cnt + LW'(1);
            end else begin
               lbl_n = num_labels;
               id_n  = BW'(1);
               cnt_n = '0;
               if (num_labels != '0) begin
                  oid_n   = BW'(1);
                  state_n = SET;
               end else begin
                  state_n = DONE;
               end
            end
         end

         SET: begin
            // Give the pipeline STAT_WAIT cycles to settle on obj_id.
            if (cnt == WT_LAST) begin
               sid_n   = id;
               sa_n    = obj_area;
               sx_n    = obj_x;
               sy_n    = obj_y;
               state_n = OUT;
            end else begin
               cnt_n = cnt + LW'(1);
            end
         end

         OUT: begin
            if (stat_ready) begin
               if (id == lbl) begin
                  oid_n   = '0;
                  state_n = DONE;
               end else begin
                  id_n    = id + BW'(1);
                  oid_n   = id + BW'(1);
                  cnt_n   = '0;
                  state_n = SET;
               end
            end
         end

         DONE: begin
            cx_n    = '0;
            cy_n    = '0;
            oid_n   = '0;
            state_n = STREAM;
         end

         default: begin
            state_n = STREAM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= STREAM;
         cx        <= '0;
         cy        <= '0;
         cnt       <= '0;
         lbl       <= '0;
         id        <= '0;
         obj_id    <= '0;
         stat_id   <= '0;
         stat_area <= '0;
         stat_x    <= '0;
         stat_y    <= '0;
         pix_en    <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_data  <= '0;
      end else begin
         state     <= state_n;
         cx        <= cx_n;
         cy        <= cy_n;
         cnt       <= cnt_n;
         lbl       <= lbl_n;
         id        <= id_n;
         obj_id    <= oid_n;
         stat_id   <= sid_n;
         stat_area <= sa_n;
         stat_x    <= sx_n;
         stat_y    <= sy_n;
         pix_en    <= pen_n;
         pix_x     <= px_n;
         pix_y     <= py_n;
         pix_data  <= pd_n;
      end
   end

endmodule
